seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_ctrl_pkg.sv | 28 ++
 rtl/seg_scan_ctrl_decode.sv | 31 +++
 rtl/seg_scan_ctrl.sv | 135 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants and types for the 8-digit 7-segment scan controller.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package seg_scan_ctrl_pkg;

    localparam logic [7:0] SEG_OFF    = 8'hFF;
    localparam logic [7:0] AN_OFF     = 8'hFF;
    localparam int         NUM_DIGITS = 8;

    typedef enum logic {ST_SHOW, ST_BLANK} scan_state_t;

    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

endpackage

// File: rtl/seg_scan_ctrl_decode.sv
// Combinational hex nibble to active-low 7-segment glyph (b and d drawn lowercase).
module seg7_hex_decode
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] glyph_n
);

    always_comb begin
        glyph_n = GLYPH_8;
        case (hex)
            4'h0: glyph_n = GLYPH_0;
            4'h1: glyph_n = GLYPH_1;
            4'h2: glyph_n = GLYPH_2;
            4'h3: glyph_n = GLYPH_3;
            4'h4: glyph_n = GLYPH_4;
            4'h5: glyph_n = GLYPH_5;
            4'h6: glyph_n = GLYPH_6;
            4'h7: glyph_n = GLYPH_7;
            4'h8: glyph_n = GLYPH_8;
            4'h9: glyph_n = GLYPH_9;
            4'hA: glyph_n = GLYPH_A;
            4'hB: glyph_n = GLYPH_B;
            4'hC: glyph_n = GLYPH_C;
            4'hD: glyph_n = GLYPH_D;
            4'hE: glyph_n = GLYPH_E;
            4'hF: glyph_n = GLYPH_F;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 8-digit common-anode display scanner with blanking guard,
// host-writable digit buffer and per-digit blink.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int GUARD     = 16,
    parameter int BLINK_DIV = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [4:0] wr_data,
    input  logic [7:0] blink_mask,
    output logic [7:0] SEG,
    output logic [7:0] AN,
    output logic       frame_tick
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FRM_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] SHOW_LEN   = CNT_W'(SCAN_DIV - GUARD);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);
    localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       digit_q, digit_d;
    scan_state_t      state_q, state_d;
    logic             init_q, init_d;
    logic             wrap_q, wrap_d;
    logic             blink_phase_q, blink_phase_d;
    logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [4:0]       dbuf_q [NUM_DIGITS];
    logic [4:0]       dbuf_d [NUM_DIGITS];
    logic [7:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;
    logic             frame_tick_q, frame_tick_d;

    logic [4:0] cur;
    logic [6:0] glyph_n;
    logic       show;

    assign cur = dbuf_q[digit_q];

    seg7_hex_decode u_dec (
        .hex     (cur[3:0]),
        .glyph_n (glyph_n)
    );

    // Digit is dark during the guard, when disabled, or in the off half of its blink.
    assign show = (state_q == ST_SHOW) && en && !(blink_phase_q && blink_mask[digit_q]);

    always_comb begin
        cnt_d         = cnt_q;
        digit_d       = digit_q;
        state_d       = state_q;
        init_d        = init_q;
        wrap_d        = 1'b0;
        blink_phase_d = blink_phase_q;
        frame_cnt_d   = frame_cnt_q;
        dbuf_d        = dbuf_q;
        if (wr_en) begin
            dbuf_d[wr_addr] = wr_data;
        end

        if (init_q) begin
            // Post-reset guard: digit 0 is first shown once this blank has elapsed.
            if (cnt_q == GUARD_LAST) begin
                cnt_d   = '0;
                init_d  = 1'b0;
                state_d = ST_SHOW;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            digit_d = digit_q + 3'd1;
            state_d = ST_SHOW;
            if (digit_q == 3'd7) begin
                wrap_d = 1'b1;
                if (frame_cnt_q == FRM_LAST) begin
                    frame_cnt_d   = '0;
                    blink_phase_d = ~blink_phase_q;
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
        end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_d >= SHOW_LEN) ? ST_BLANK : ST_SHOW;
        end

        an_d         = show ? ~(8'b1 << digit_q) : AN_OFF;
        seg_d        = show ? {~cur[4], glyph_n} : SEG_OFF;
        frame_tick_d = wrap_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            digit_q       <= '0;
            state_q       <= ST_BLANK;
            init_q        <= 1'b1;
            wrap_q        <= 1'b0;
            blink_phase_q <= 1'b0;
            frame_cnt_q   <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                dbuf_q[i] <= '0;
            end
            an_q          <= AN_OFF;
            seg_q         <= SEG_OFF;
            frame_tick_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            digit_q       <= digit_d;
            state_q       <= state_d;
            init_q        <= init_d;
            wrap_q        <= wrap_d;
            blink_phase_q <= blink_phase_d;
            frame_cnt_q   <= frame_cnt_d;
            dbuf_q        <= dbuf_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign AN         = an_q;
    assign SEG        = seg_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed plus randomized bench for seg_scan_ctrl against a time-based display model.
module tb_seg_scan_ctrl;

    localparam int SCAN_DIV  = 8;
    localparam int GUARD     = 2;
    localparam int BLINK_DIV = 2;
    localparam int FRAME     = 8 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [4:0] wr_data = 5'd0;
    logic [7:0] blink_mask = 8'h00;
    logic [7:0] seg;
    logic [7:0] an;
    logic       frame_tick;

    int checks = 0;
    int fails  = 0;
    int t      = 0;
    logic [4:0] mbuf [8];
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .SCAN_DIV  (SCAN_DIV),
        .GUARD     (GUARD),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .blink_mask (blink_mask),
        .SEG        (seg),
        .AN         (an),
        .frame_tick (frame_tick)
    );

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at t=%0d: observed %h expected %h", tag, t, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at t=%0d: observed %b expected %b", tag, t, obs, exp);
        end
    endtask

    // Display timeline since reset release: GUARD idle cycles, then slots of SCAN_DIV
    // cycles, 8 slots per frame, blink phase flips every BLINK_DIV frames.
    function automatic void expect_out(output logic [7:0] ea, output logic [7:0] es,
                                       output logic ef);
        int n;
        n  = t - GUARD;
        ea = 8'hFF;
        es = 8'hFF;
        ef = 1'b0;
        if (n >= 0) begin
            int cnt, slot, dig, frame;
            logic ph;
            cnt   = n % SCAN_DIV;
            slot  = n / SCAN_DIV;
            dig   = slot % 8;
            frame = slot / 8;
            ph    = ((frame / BLINK_DIV) % 2) == 1;
            ef    = (n > 0) && (n % FRAME == 0);
            if (cnt < SCAN_DIV - GUARD && en && !(ph && blink_mask[dig])) begin
                ea = ~(8'd1 << dig);
                es = {~mbuf[dig][4], glyph[mbuf[dig][3:0]]};
            end
        end
    endfunction

    task automatic cycle();
        logic [7:0] ea, es;
        logic       ef;
        expect_out(ea, es, ef);
        @(posedge clk);
        #1;
        t++;
        if (wr_en) mbuf[wr_addr] = wr_data;
        check8("AN", an, ea);
        check8("SEG", seg, es);
        check1("frame_tick", frame_tick, ef);
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        t = 0;
        for (int i = 0; i < 8; i++) mbuf[i] = 5'h00;
    endtask

    initial begin
        int guard_cnt;

        // Reset held across several edges
        repeat (3) @(posedge clk);
        #1;
        check8("rst_AN", an, 8'hFF);
        check8("rst_SEG", seg, 8'hFF);
        check1("rst_tick", frame_tick, 1'b0);
        release_reset();
        en = 1'b1;

        // Load digits 0..7 with their own index
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 5'(i);
            cycle();
        end
        wr_en = 1'b0;
        repeat (2 * FRAME) cycle();

        // Overwrite digit 3 while it is on display
        guard_cnt = 0;
        while (!((((t - GUARD) / SCAN_DIV) % 8 == 3) && ((t - GUARD) % SCAN_DIV == 1))
               && guard_cnt < 200) begin
            cycle();
            guard_cnt++;
        end
        check1("find_digit3", guard_cnt < 200, 1'b1);
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 5'h18;
        cycle();
        wr_en = 1'b0;
        cycle();
        check8("wr_shown_SEG", seg, 8'h00);
        check8("wr_shown_AN", an, 8'hF7);

        // Blink digit 0 over several frames
        blink_mask = 8'h01;
        repeat (4 * FRAME + 5) cycle();

        // Enable dropped mid-show, then restored
        blink_mask = 8'h00;
        repeat (3) cycle();
        en = 1'b0;
        repeat (20) cycle();
        en = 1'b1;
        repeat (30) cycle();

        // Randomized writes, enable and mask activity
        for (int i = 0; i < 1500; i++) begin
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 5'($urandom_range(0, 31));
            en      = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) == 0) blink_mask = 8'($urandom_range(0, 255));
            cycle();
        end
        wr_en = 1'b0;
        en    = 1'b1;
        blink_mask = 8'h00;

        // Asynchronous reset in the middle of a SHOW period
        guard_cnt = 0;
        while (((t - GUARD) % SCAN_DIV != 2) && guard_cnt < 20) begin
            cycle();
            guard_cnt++;
        end
        rst_n = 1'b0;
        #1;
        check8("async_rst_AN", an, 8'hFF);
        check8("async_rst_SEG", seg, 8'hFF);
        check1("async_rst_tick", frame_tick, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        release_reset();
        repeat (3) cycle();
        check8("post_rst_AN", an, 8'hFE);
        check8("post_rst_SEG", seg, 8'hC0);
        repeat (FRAME + 10) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
